// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI bus arbiter.
// Holds the FSM state encoding and the index-width helper.
package spi_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } arb_state_t;

   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr_pick.sv
// Round-robin priority search: first set request after the last owner.
// Purely combinational; the caller registers the result.
module rr_pick
   import spi_arb_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int W    = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [W-1:0]    last,
   output logic [W-1:0]    win,
   output logic            valid
);

   int idx;

   // Walk from the farthest candidate back so the nearest one wins.
   always_comb begin
      win   = '0;
      valid = 1'b0;
      idx   = 0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = (int'(last) + k) % NREQ;
         if (req[idx]) begin
            win   = W'(idx);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI pad set between NREQ master engines.
// Define SPI_ARB_TIMEOUT_EN to enable the grant hold timeout and requester mask.
module spi_bus_arbiter
   import spi_arb_pkg::*;
#(
   parameter int   NREQ       = 2,
   parameter int   GAP_CYCLES = 8,
   parameter logic CPOL       = 1'b0
`ifdef SPI_ARB_TIMEOUT_EN
   ,parameter int  TIMEOUT    = 2**20
`endif
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic [NREQ-1:0]          req,
   output logic [NREQ-1:0]          gnt,
   input  logic [NREQ-1:0]          sclk_in,
   input  logic [NREQ-1:0]          mosi_in,
   input  logic [NREQ-1:0]          cs_in,
   output logic                     SCLK,
   output logic                     MOSI,
   output logic [NREQ-1:0]          CS,
   output logic                     busy,
   output logic [idx_w(NREQ)-1:0]   owner,
   output logic                     timeout_err
);

   localparam int W  = idx_w(NREQ);
   localparam int GW = idx_w(GAP_CYCLES);

   arb_state_t      state_q, state_d;
   logic [NREQ-1:0] gnt_d;
   logic [W-1:0]    owner_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic [NREQ-1:0] arb_req;
   logic [W-1:0]    pick;
   logic            pick_vld;

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int HW = idx_w(TIMEOUT);

   logic [HW-1:0]   hold_q, hold_d;
   logic [NREQ-1:0] mask_q, mask_d;
   logic            terr_q, terr_d;

   assign arb_req     = req & ~mask_q;
   assign timeout_err = terr_q;
`else
   assign arb_req     = req;
   assign timeout_err = 1'b0;
`endif

   rr_pick #(
      .NREQ  (NREQ),
      .W     (W)
   ) u_pick (
      .req   (arb_req),
      .last  (owner),
      .win   (pick),
      .valid (pick_vld)
   );

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt;
      owner_d = owner;
      gap_d   = gap_q;
`ifdef SPI_ARB_TIMEOUT_EN
      hold_d  = hold_q;
      terr_d  = 1'b0;
      mask_d  = mask_q & req;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               state_d     = ST_GRANT;
               gnt_d       = '0;
               gnt_d[pick] = 1'b1;
               owner_d     = pick;
`ifdef SPI_ARB_TIMEOUT_EN
               hold_d      = '0;
`endif
            end
         end
         ST_GRANT: begin
            if (!req[owner]) begin
               state_d = ST_GAP;
               gnt_d   = '0;
               gap_d   = '0;
            end
`ifdef SPI_ARB_TIMEOUT_EN
            // Forced release: owner stays masked until it drops req.
            else if (hold_q == HW'(TIMEOUT - 1)) begin
               state_d       = ST_GAP;
               gnt_d         = '0;
               gap_d         = '0;
               terr_d        = 1'b1;
               mask_d[owner] = 1'b1;
            end else begin
               hold_d = hold_q + 1'b1;
            end
`endif
         end
         ST_GAP: begin
            if (gap_q == GW'(GAP_CYCLES - 1)) begin
               state_d = ST_IDLE;
               gap_d   = '0;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         gnt     <= '0;
         owner   <= W'(NREQ - 1);
         gap_q   <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
         hold_q  <= '0;
         mask_q  <= '0;
         terr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         gnt     <= gnt_d;
         owner   <= owner_d;
         gap_q   <= gap_d;
`ifdef SPI_ARB_TIMEOUT_EN
         hold_q  <= hold_d;
         mask_q  <= mask_d;
         terr_q  <= terr_d;
`endif
      end
   end

   assign busy = (state_q != ST_IDLE);

   always_comb begin
      SCLK = CPOL;
      MOSI = 1'b0;
      CS   = '1;
      if (state_q == ST_GRANT) begin
         SCLK      = sclk_in[owner];
         MOSI      = mosi_in[owner];
         CS[owner] = cs_in[owner];
      end
   end

endmodule
